// File: rtl/quadrature_decoder.sv
// rtl/quadrature_decoder.sv - quadrature A/B decoder with filtering and 16-bit position count
//
// Purpose: synchronises and glitch-filters an encoder A/B pair, decodes
// legal Gray-code steps into a wrapping 16-bit up/down count, and flags
// illegal double transitions with a sticky error bit.
//
// Ports:
//   clk        rising-edge clock (sole domain)
//   reset      synchronous active-high reset
//   quad_a     encoder phase A (asynchronous)
//   quad_b     encoder phase B (asynchronous)
//   clear      zero count and error
//   load       count <= load_value
//   load_value preload value
//   count      position, wraps modulo 2^16
//   dir        direction of last valid step (1 = up)
//   step       one-cycle pulse per applied legal step
//   error      sticky illegal-transition flag
module quadrature_decoder #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        quad_a,
  input  logic        quad_b,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] count,
  output logic        dir,
  output logic        step,
  output logic        error
);

  // Stability counter saturates here; acceptance happens on the cycle the
  // counter sits at this value with the input still unchanged.
  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  logic [1:0]  sync1_q;
  logic [1:0]  sync2_q;
  logic [1:0]  s_prev_q;
  logic [3:0]  stab_cnt_q, stab_cnt_d;
  logic [1:0]  f_q;
  logic        init_q;
  logic [15:0] count_q, count_d;
  logic        dir_q, dir_d;
  logic        step_q, step_d;
  logic        error_q, error_d;

  logic        stable;
  logic        accept;
  logic        decode_en;
  logic [1:0]  old_idx;
  logic [1:0]  new_idx;
  logic [1:0]  delta;
  logic        fwd;
  logic        rev;
  logic        illegal;

  always_comb begin
    stable = (sync2_q == s_prev_q);

    stab_cnt_d = stab_cnt_q;
    if (!stable) begin
      stab_cnt_d = 4'd0;
    end else if (stab_cnt_q != CNT_MAX) begin
      stab_cnt_d = stab_cnt_q + 4'd1;
    end

    accept    = stable && (stab_cnt_q == CNT_MAX) && (!init_q || (sync2_q != f_q));
    decode_en = accept && init_q;

    // Map {A,B} Gray states 00,10,11,01 onto phase 0..3; the phase
    // difference mod 4 then gives +1 forward, -1 reverse, 2 illegal.
    old_idx = {f_q[0], f_q[1] ^ f_q[0]};
    new_idx = {sync2_q[0], sync2_q[1] ^ sync2_q[0]};
    delta   = new_idx - old_idx;

    fwd     = decode_en && (delta == 2'd1);
    rev     = decode_en && (delta == 2'd3);
    illegal = decode_en && (delta == 2'd2);

    count_d = count_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    error_d = error_q;

    if (fwd || rev) begin
      dir_d = fwd;
    end

    if (clear) begin
      count_d = 16'h0000;
      error_d = 1'b0;
    end else if (load) begin
      count_d = load_value;
      if (illegal) begin
        error_d = 1'b1;
      end
    end else begin
      if (fwd) begin
        count_d = count_q + 16'd1;
      end else if (rev) begin
        count_d = count_q - 16'd1;
      end
      step_d = fwd || rev;
      if (illegal) begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      s_prev_q   <= 2'b00;
      stab_cnt_q <= 4'd0;
      f_q        <= 2'b00;
      init_q     <= 1'b0;
      count_q    <= 16'h0000;
      dir_q      <= 1'b1;
      step_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      sync1_q    <= {quad_a, quad_b};
      sync2_q    <= sync1_q;
      s_prev_q   <= sync2_q;
      stab_cnt_q <= stab_cnt_d;
      if (accept) begin
        f_q    <= sync2_q;
        init_q <= 1'b1;
      end
      count_q <= count_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      error_q <= error_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign error = error_q;

endmodule
